// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider: per-channel divided clock and
// period tick, with divisor updates held pending until a period boundary.
module clk_div_multi #(
   parameter int N_CH        = 2,
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = 10,
   parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic [N_CH-1:0]  en,
   input  logic             sync,
   input  logic             div_valid,
   input  logic [CH_W-1:0]  div_ch,
   input  logic [DIV_W-1:0] div_val,
   output logic             div_ready,
   output logic [N_CH-1:0]  clk_out,
   output logic [N_CH-1:0]  tick
);

   localparam logic [DIV_W-1:0] DEF_D = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] MIN_D = DIV_W'(2);
   localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);

   // Handshake: valid/ready transfer on a clock edge where both are high; ready
   // is low while the addressed channel already holds a pending divisor, and
   // never high for a channel index that does not exist.
   logic [N_CH-1:0]  pend;
   logic             accept;
   logic [DIV_W-1:0] wr_val;

   always_comb begin
      div_ready = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (div_ch == CH_W'(i)) div_ready = !pend[i];
      end
   end

   assign accept = div_valid && div_ready;
   assign wr_val = (div_val < MIN_D) ? MIN_D : div_val;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic [DIV_W-1:0] d;
      logic [DIV_W-1:0] pend_val;
      logic [DIV_W-1:0] p;
      logic [DIV_W-1:0] h;
      logic             pend_r;
      logic             clk_r;
      logic             tick_r;
      logic             sel;

      assign h       = d - (d >> 1);
      assign sel     = accept && (div_ch == CH_W'(g));
      assign pend[g] = pend_r;
      assign clk_out[g] = clk_r;
      assign tick[g]    = tick_r;

      always_ff @(posedge clk_in) begin
         if (rst) begin
            d        <= DEF_D;
            pend_val <= '0;
            pend_r   <= 1'b0;
            p        <= '0;
            clk_r    <= 1'b0;
            tick_r   <= 1'b0;
         end else begin
            if (!en[g]) begin
               p      <= '0;
               clk_r  <= 1'b0;
               tick_r <= 1'b0;
               if (pend_r) begin
                  d      <= pend_val;
                  pend_r <= 1'b0;
               end
            end else if (sync) begin
               // Phase 0 is always high, so the freshly applied divisor only
               // matters for the following phases.
               clk_r  <= 1'b1;
               tick_r <= 1'b1;
               p      <= ONE;
               if (pend_r) begin
                  d      <= pend_val;
                  pend_r <= 1'b0;
               end
            end else begin
               clk_r  <= (p < h);
               tick_r <= (p == '0);
               if (p == d - ONE) begin
                  p <= '0;
                  if (pend_r) begin
                     d      <= pend_val;
                     pend_r <= 1'b0;
                  end
               end else begin
                  p <= p + ONE;
               end
            end
            // Acceptance requires pend_r low, so it never collides with an apply.
            if (sel) begin
               pend_val <= wr_val;
               pend_r   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: per-period waveform queue model checked every cycle,
// plus directed scenarios with hand-computed window counts.
module tb_clk_div_multi;

   localparam int N_CH  = 2;
   localparam int DIV_W = 16;
   localparam int CH_W  = 1;

   logic             clk_in;
   logic             rst;
   logic [N_CH-1:0]  en;
   logic             sync;
   logic             div_valid;
   logic [CH_W-1:0]  div_ch;
   logic [DIV_W-1:0] div_val;
   logic             div_ready;
   logic [N_CH-1:0]  clk_out;
   logic [N_CH-1:0]  tick;

   int checks   = 0;
   int failures = 0;

   clk_div_multi #(.N_CH(N_CH), .DIV_W(DIV_W), .DEFAULT_DIV(10)) dut (
      .clk_in(clk_in), .rst(rst), .en(en), .sync(sync),
      .div_valid(div_valid), .div_ch(div_ch), .div_val(div_val),
      .div_ready(div_ready), .clk_out(clk_out), .tick(tick)
   );

   // clock / reset
   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // model: each channel's upcoming outputs as a queue of {clk,tick} per cycle
   logic [1:0] exp_q [N_CH][$];
   int         m_d    [N_CH];
   int         m_pval [N_CH];
   bit         m_pend [N_CH];
   bit         exp_clk [N_CH];
   bit         exp_tick[N_CH];
   bit         m_started = 0;

   task automatic fill_period(input int ch);
      int hi;
      hi = (m_d[ch] + 1) / 2;
      for (int k = 0; k < m_d[ch]; k++) exp_q[ch].push_back({k < hi, k == 0});
   endtask

   task automatic apply_pend(input int ch);
      if (m_pend[ch]) begin
         m_d[ch]    = m_pval[ch];
         m_pend[ch] = 0;
      end
   endtask

   always @(posedge clk_in) begin
      bit acc [N_CH];
      logic [1:0] e;
      for (int i = 0; i < N_CH; i++)
         acc[i] = div_valid && (int'(div_ch) == i) && !m_pend[i];
      for (int i = 0; i < N_CH; i++) begin
         if (rst) begin
            m_d[i] = 10; m_pend[i] = 0; m_pval[i] = 0;
            exp_q[i].delete();
            exp_clk[i] = 0; exp_tick[i] = 0;
         end else begin
            if (!en[i]) begin
               exp_q[i].delete();
               exp_clk[i] = 0; exp_tick[i] = 0;
               apply_pend(i);
            end else begin
               if (sync) begin
                  exp_q[i].delete();
                  apply_pend(i);
               end
               if (exp_q[i].size() == 0) fill_period(i);
               e = exp_q[i].pop_front();
               exp_clk[i] = e[1]; exp_tick[i] = e[0];
               // period finished on this edge: pending divisor shapes the next one
               if (exp_q[i].size() == 0) apply_pend(i);
            end
            if (acc[i]) begin
               m_pend[i] = 1;
               m_pval[i] = (int'(div_val) < 2) ? 2 : int'(div_val);
            end
         end
      end
      if (rst) m_started = 1;
   end

   // scoreboard compare every cycle, away from the active edge
   always @(negedge clk_in) begin
      if (m_started) begin
         for (int i = 0; i < N_CH; i++) begin
            checks++;
            if (clk_out[i] !== exp_clk[i]) begin
               failures++;
               $display("FAIL clk_out[%0d] t=%0t actual=%b required=%b", i, $time, clk_out[i], exp_clk[i]);
            end
            checks++;
            if (tick[i] !== exp_tick[i]) begin
               failures++;
               $display("FAIL tick[%0d] t=%0t actual=%b required=%b", i, $time, tick[i], exp_tick[i]);
            end
         end
         checks++;
         if (div_ready !== !m_pend[int'(div_ch)]) begin
            failures++;
            $display("FAIL div_ready ch=%0d t=%0t actual=%b required=%b", div_ch, $time, div_ready, !m_pend[int'(div_ch)]);
         end
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic measure(input int n, output int hi0, output int tk0, output int hi1, output int tk1);
      hi0 = 0; tk0 = 0; hi1 = 0; tk1 = 0;
      repeat (n) begin
         step();
         hi0 += int'(clk_out[0]); tk0 += int'(tick[0]);
         hi1 += int'(clk_out[1]); tk1 += int'(tick[1]);
      end
   endtask

   task automatic write(input int ch, input int val);
      div_valid = 1'b1;
      div_ch    = CH_W'(ch);
      div_val   = DIV_W'(val);
   endtask

   initial begin
      int hi0, tk0, hi1, tk1, k;
      bit found;
      rst = 1'b1; en = 2'b00; sync = 1'b0;
      div_valid = 1'b0; div_ch = '0; div_val = '0;

      // reset defaults
      en = 2'b11;
      repeat (3) begin
         step();
         chk("rst_clk_out", int'(clk_out), 0);
         chk("rst_tick", int'(tick), 0);
      end
      rst = 1'b0;
      measure(10, hi0, tk0, hi1, tk1);
      chk("def_hi0", hi0, 5); chk("def_tk0", tk0, 1);
      chk("def_hi1", hi1, 5); chk("def_tk1", tk1, 1);

      // boundary-aligned update on ch0 at phase 4
      repeat (4) step();
      write(0, 3);
      chk("upd_ready_before", int'(div_ready), 1);
      step();
      div_valid = 1'b0;
      chk("upd_ready_drop", int'(div_ready), 0);
      repeat (4) step();
      chk("upd_ready_hold", int'(div_ready), 0);
      step();
      chk("upd_ready_back", int'(div_ready), 1);
      measure(6, hi0, tk0, hi1, tk1);
      chk("d3_hi0", hi0, 4); chk("d3_tk0", tk0, 2);

      // clamp and handshake on disabled ch1
      en = 2'b01;
      step();
      write(1, 0);
      chk("clamp_ready0", int'(div_ready), 1);
      step();
      div_val = DIV_W'(5);
      chk("clamp_held_off", int'(div_ready), 0);
      step();
      chk("clamp_ready_after_apply", int'(div_ready), 1);
      div_val = DIV_W'(1);
      step();
      div_valid = 1'b0;
      chk("clamp_ready_pend1", int'(div_ready), 0);
      step();
      chk("clamp_ready_applied1", int'(div_ready), 1);
      en = 2'b11;
      measure(6, hi0, tk0, hi1, tk1);
      chk("d2_hi1", hi1, 3); chk("d2_tk1", tk1, 3);

      // odd divisor on ch0
      write(0, 7);
      step();
      div_valid = 1'b0;
      en = 2'b10;
      step();
      en = 2'b11;
      measure(7, hi0, tk0, hi1, tk1);
      chk("d7_hi0_a", hi0, 4); chk("d7_tk0_a", tk0, 1);
      measure(7, hi0, tk0, hi1, tk1);
      chk("d7_hi0_b", hi0, 4); chk("d7_tk0_b", tk0, 1);

      // sync alignment: ch0 D=4, ch1 D=6
      write(0, 4);
      step();
      write(1, 6);
      step();
      div_valid = 1'b0;
      repeat (10) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      chk("sync_tick", int'(tick), 3);
      chk("sync_clk_out", int'(clk_out), 3);
      k = 0; found = 0;
      while (!found && k < 30) begin
         step();
         k++;
         if (tick == 2'b11) found = 1;
      end
      chk("sync_coincide_gap", k, 12);

      // write accepted on ch0's wrap edge (phase 3 of D=4)
      repeat (2) step();
      write(0, 5);
      chk("wrap_ready", int'(div_ready), 1);
      step();
      div_valid = 1'b0;
      chk("wrap_ready_drop", int'(div_ready), 0);
      measure(4, hi0, tk0, hi1, tk1);
      chk("wrap_old_hi0", hi0, 2); chk("wrap_old_tk0", tk0, 1);
      chk("wrap_ready_back", int'(div_ready), 1);
      measure(5, hi0, tk0, hi1, tk1);
      chk("wrap_new_hi0", hi0, 3); chk("wrap_new_tk0", tk0, 1);

      // reset mid-period with a pending write
      write(0, 3);
      step();
      div_valid = 1'b0;
      step();
      rst = 1'b1;
      step();
      chk("mid_rst_clk_out", int'(clk_out), 0);
      chk("mid_rst_tick", int'(tick), 0);
      chk("mid_rst_ready", int'(div_ready), 1);
      rst = 1'b0;
      measure(10, hi0, tk0, hi1, tk1);
      chk("post_rst_hi0", hi0, 5); chk("post_rst_tk0", tk0, 1);
      chk("post_rst_hi1", hi1, 5); chk("post_rst_tk1", tk1, 1);
      repeat (12) step();

      @(posedge clk_in);
      @(negedge clk_in);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
